// File: rtl/chess_render_pkg.sv
`default_nettype none
// ============================================================================
// Module      : chess_render_pkg
// Description : Shared constants for the chess board renderer: RGB565
//               colours, square-byte field positions, chessman codes and
//               the frame state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package chess_render_pkg;

  // RGB565 palette
  localparam logic [15:0] c_BACKGROUND  = 16'h0000;
  localparam logic [15:0] c_CURSOR      = 16'hFFE0;
  localparam logic [15:0] c_LOCK_CURSOR = 16'hF800;
  localparam logic [15:0] c_WHITE_PIECE = 16'hFFFF;
  localparam logic [15:0] c_BLACK_PIECE = 16'h2104;
  localparam logic [15:0] c_LOCK_FILL   = 16'h07E0;
  localparam logic [15:0] c_LIGHT       = 16'hEF7D;
  localparam logic [15:0] c_DARK        = 16'h8A22;

  // Square byte layout: [2:0] chessman, 3 owner, 4 cursor, 5 lock source,
  // 6 lock cursor, 7 unused
  localparam int c_PIECE_MSB       = 2;
  localparam int c_PIECE_LSB       = 0;
  localparam int c_BIT_OWNER       = 3;
  localparam int c_BIT_CURSOR      = 4;
  localparam int c_BIT_LOCK_SRC    = 5;
  localparam int c_BIT_LOCK_CURSOR = 6;

  // Chessman codes
  localparam logic [2:0] c_PAWN   = 3'd1;
  localparam logic [2:0] c_KNIGHT = 3'd2;
  localparam logic [2:0] c_ROOK   = 3'd3;
  localparam logic [2:0] c_BISHOP = 3'd4;
  localparam logic [2:0] c_QUEEN  = 3'd5;
  localparam logic [2:0] c_KING   = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DRAW = 2'd2,
    DONE = 2'd3
  } renderState_t;

endpackage
`default_nettype wire

// File: rtl/chess_piece_sprite_rom.sv
`default_nettype none
// ============================================================================
// Module      : chess_piece_sprite_rom
// Description : Combinational 16x16 1-bit glyph ROM for the six chessmen.
//               Glyphs are stored as the left half (8 columns) of each row
//               and mirrored for the right half. Row 0 is the top line.
//               Used only when CHESS_RENDER_SPRITE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module chess_piece_sprite_rom
  import chess_render_pkg::*;
(
  input  logic [2:0] chessman,
  input  logic [3:0] row,
  input  logic [3:0] col,
  output logic       glyphBit
);

  // One byte per row, row 0 in the top byte; bit 7 is the leftmost column
  localparam logic [127:0] c_GLYPH_PAWN   = 128'h0000_0001_0303_0101_0303_0707_0F1F_1F00;
  localparam logic [127:0] c_GLYPH_KNIGHT = 128'h0000_060F_1F3F_3707_0F0F_0F0F_1F3F_3F00;
  localparam logic [127:0] c_GLYPH_ROOK   = 128'h0000_2D3F_3F1F_0F0F_0F0F_0F0F_1F3F_3F00;
  localparam logic [127:0] c_GLYPH_BISHOP = 128'h0001_0307_0F0D_0F07_0303_0707_0F1F_3F00;
  localparam logic [127:0] c_GLYPH_QUEEN  = 128'h0025_252D_3F3F_1F1F_0F0F_0F1F_1F3F_3F00;
  localparam logic [127:0] c_GLYPH_KING   = 128'h0001_0701_0327_3F3F_3F1F_0F0F_1F3F_3F00;

  logic [127:0] w_glyph;
  logic [7:0]   w_rowBits;
  logic [2:0]   w_half;

  // Select the glyph for the requested chessman
  always_comb begin
    w_glyph = '0;
    case (chessman)
      c_PAWN:   w_glyph = c_GLYPH_PAWN;
      c_KNIGHT: w_glyph = c_GLYPH_KNIGHT;
      c_ROOK:   w_glyph = c_GLYPH_ROOK;
      c_BISHOP: w_glyph = c_GLYPH_BISHOP;
      c_QUEEN:  w_glyph = c_GLYPH_QUEEN;
      c_KING:   w_glyph = c_GLYPH_KING;
      default:  w_glyph = '0;
    endcase
  end

  // Row r lives at bit offset (15-r)*8, i.e. {~r, 3'b000}
  assign w_rowBits = w_glyph[{~row, 3'b000} +: 8];
  // Right-half columns mirror onto the stored left half
  assign w_half    = col[3] ? ~col[2:0] : col[2:0];
  assign glyphBit  = w_rowBits[~w_half];

endmodule
`default_nettype wire

// File: rtl/chess_board_renderer.sv
`default_nettype none
// ============================================================================
// Module      : chess_board_renderer
// Description : Snapshots the flattened 64-square layout on a frame request
//               and streams the board as RGB565 pixels over a valid/ready
//               handshake in raster order, then pulses frameDone.
//               Define CHESS_RENDER_SPRITE_EN to draw pieces from the glyph
//               ROM instead of filled inset squares.
// Revision    : 1.0 - initial release
// ============================================================================
module chess_board_renderer
  import chess_render_pkg::*;
#(
  parameter int CHESS_SQUARES = 64,
  parameter int SQUARE_WIDTH  = 8,
  parameter int MATRIX_WIDTH  = CHESS_SQUARES * SQUARE_WIDTH,
  parameter int SCREEN_WIDTH  = 240,
  parameter int SCREEN_HEIGHT = 320,
  parameter int SQUARE_PX     = 30,
  parameter int BOARD_Y       = 40
)(
  input  logic                    clock,
  input  logic                    resetApp,
  input  logic [MATRIX_WIDTH-1:0] Layout,
  input  logic                    frameRequest,
  input  logic                    pixelReady,
  output logic                    pixelWrite,
  output logic [15:0]             pixelData,
  output logic                    frameBusy,
  output logic                    frameDone
);

  localparam int c_XW = $clog2(SCREEN_WIDTH);
  localparam int c_YW = $clog2(SCREEN_HEIGHT + 1);
  localparam int c_PW = $clog2(SQUARE_PX);
  localparam logic [c_XW-1:0] c_X_LAST    = c_XW'(SCREEN_WIDTH - 1);
  localparam logic [c_YW-1:0] c_Y_LAST    = c_YW'(SCREEN_HEIGHT - 1);
  localparam logic [c_YW-1:0] c_BOARD_TOP = c_YW'(BOARD_Y);
  localparam logic [c_YW-1:0] c_BOARD_END = c_YW'(BOARD_Y + 8 * SQUARE_PX);
  localparam logic [c_PW-1:0] c_PX_LAST   = c_PW'(SQUARE_PX - 1);
  localparam logic [c_PW-1:0] c_EDGE_LO   = c_PW'(2);
  localparam logic [c_PW-1:0] c_EDGE_HI   = c_PW'(SQUARE_PX - 3);
`ifdef CHESS_RENDER_SPRITE_EN
  localparam logic [c_PW-1:0] c_PIECE_LO  = c_PW'(7);
  localparam logic [c_PW-1:0] c_PIECE_HI  = c_PW'(22);
`else
  localparam logic [c_PW-1:0] c_PIECE_LO  = c_PW'(8);
  localparam logic [c_PW-1:0] c_PIECE_HI  = c_PW'(21);
`endif

  renderState_t          r_state, w_stateNext;
  logic [MATRIX_WIDTH-1:0] r_snapshot;
  logic [c_XW-1:0]       r_x, w_xNext;
  logic [c_YW-1:0]       r_y, w_yNext;
  logic [c_PW-1:0]       r_pxX, w_pxXNext, r_pxY, w_pxYNext;
  logic [2:0]            r_col, w_colNext, r_row, w_rowNext;
  logic                  r_pixelWrite;
  logic [15:0]           r_pixelData, w_pixelNext;
  logic                  w_accept, w_lastPixel;
  logic [6:0]            w_sqByte;
  logic                  w_inBoard, w_border, w_pieceArea, w_pieceHit;

  assign w_accept    = r_pixelWrite & pixelReady;
  assign w_lastPixel = (r_x == c_X_LAST) && (r_y == c_Y_LAST);

  // Frame state register
  always_ff @(posedge clock or negedge resetApp) begin
    if (!resetApp) r_state <= IDLE;
    else           r_state <= w_stateNext;
  end

  // Frame sequencing; requests outside IDLE are dropped
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (frameRequest) w_stateNext = LOAD;
      LOAD:    w_stateNext = DRAW;
      DRAW:    if (w_accept && w_lastPixel) w_stateNext = DONE;
      DONE:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Next scan position: LOAD rewinds to (0,0), each accept steps x then y.
  // The in-square counters wrap at SQUARE_PX so no division is needed; the
  // line counters restart on the first board line.
  always_comb begin
    w_xNext   = r_x;
    w_yNext   = r_y;
    w_pxXNext = r_pxX;
    w_pxYNext = r_pxY;
    w_colNext = r_col;
    w_rowNext = r_row;
    if (r_state == LOAD) begin
      w_xNext   = '0;
      w_yNext   = '0;
      w_pxXNext = '0;
      w_pxYNext = '0;
      w_colNext = '0;
      w_rowNext = '0;
    end else if (w_accept && !w_lastPixel) begin
      if (r_x == c_X_LAST) begin
        w_xNext   = '0;
        w_pxXNext = '0;
        w_colNext = '0;
        w_yNext   = r_y + 1'b1;
        if (w_yNext == c_BOARD_TOP) begin
          w_pxYNext = '0;
          w_rowNext = '0;
        end else if (r_pxY == c_PX_LAST) begin
          w_pxYNext = '0;
          w_rowNext = r_row + 1'b1;
        end else begin
          w_pxYNext = r_pxY + 1'b1;
        end
      end else begin
        w_xNext = r_x + 1'b1;
        if (r_pxX == c_PX_LAST) begin
          w_pxXNext = '0;
          w_colNext = r_col + 1'b1;
        end else begin
          w_pxXNext = r_pxX + 1'b1;
        end
      end
    end
  end

  // Square byte under the next pixel (bit 7 carries nothing for rendering)
  assign w_sqByte    = r_snapshot[{w_rowNext, w_colNext, 3'b000} +: 7];
  assign w_inBoard   = (w_yNext >= c_BOARD_TOP) && (w_yNext < c_BOARD_END);
  assign w_border    = (w_pxXNext < c_EDGE_LO) || (w_pxXNext > c_EDGE_HI) ||
                       (w_pxYNext < c_EDGE_LO) || (w_pxYNext > c_EDGE_HI);
  assign w_pieceArea = (w_pxXNext >= c_PIECE_LO) && (w_pxXNext <= c_PIECE_HI) &&
                       (w_pxYNext >= c_PIECE_LO) && (w_pxYNext <= c_PIECE_HI);

`ifdef CHESS_RENDER_SPRITE_EN
  logic w_glyphBit;

  chess_piece_sprite_rom u_spriteRom (
    .chessman (w_sqByte[c_PIECE_MSB:c_PIECE_LSB]),
    .row      (4'(w_pxYNext - c_PIECE_LO)),
    .col      (4'(w_pxXNext - c_PIECE_LO)),
    .glyphBit (w_glyphBit)
  );

  assign w_pieceHit = w_pieceArea && (w_sqByte[c_PIECE_MSB:c_PIECE_LSB] != 3'd0) && w_glyphBit;
`else
  assign w_pieceHit = w_pieceArea && (w_sqByte[c_PIECE_MSB:c_PIECE_LSB] != 3'd0);
`endif

  // Colour priority: cursor border, piece, lock fill, square shade
  always_comb begin
    w_pixelNext = c_BACKGROUND;
    if (w_inBoard) begin
      if (w_border && w_sqByte[c_BIT_CURSOR])
        w_pixelNext = w_sqByte[c_BIT_LOCK_CURSOR] ? c_LOCK_CURSOR : c_CURSOR;
      else if (w_pieceHit)
        w_pixelNext = w_sqByte[c_BIT_OWNER] ? c_WHITE_PIECE : c_BLACK_PIECE;
      else if (w_sqByte[c_BIT_LOCK_SRC])
        w_pixelNext = c_LOCK_FILL;
      else
        w_pixelNext = (w_rowNext[0] ^ w_colNext[0]) ? c_DARK : c_LIGHT;
    end
  end

  // Snapshot, scan counters and the registered pixel output
  always_ff @(posedge clock or negedge resetApp) begin
    if (!resetApp) begin
      r_snapshot   <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_pxX        <= '0;
      r_pxY        <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_pixelWrite <= 1'b0;
      r_pixelData  <= '0;
    end else begin
      if (r_state == IDLE && frameRequest) r_snapshot <= Layout;
      r_x   <= w_xNext;
      r_y   <= w_yNext;
      r_pxX <= w_pxXNext;
      r_pxY <= w_pxYNext;
      r_col <= w_colNext;
      r_row <= w_rowNext;
      if (r_state == LOAD) begin
        r_pixelWrite <= 1'b1;
        r_pixelData  <= w_pixelNext;
      end else if (w_accept) begin
        if (w_lastPixel) begin
          r_pixelWrite <= 1'b0;
          r_pixelData  <= '0;
        end else begin
          r_pixelData  <= w_pixelNext;
        end
      end
    end
  end

  assign pixelWrite = r_pixelWrite;
  assign pixelData  = r_pixelData;
  assign frameBusy  = (r_state != IDLE);
  assign frameDone  = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_chess_board_renderer.sv
`default_nettype none
// ============================================================================
// Module      : tb_chess_board_renderer
// Description : Directed self-checking bench for chess_board_renderer:
//               reset abort, full frame with stall and mid-frame layout
//               rewrite, and a follow-up frame showing the new layout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chess_board_renderer;

  logic         clock;
  logic         resetApp;
  logic [511:0] Layout;
  logic         frameRequest;
  logic         pixelReady;
  logic         pixelWrite;
  logic [15:0]  pixelData;
  logic         frameBusy;
  logic         frameDone;

  int testsRun    = 0;
  int testsFailed = 0;

  int          spotN;
  int          spotX [16];
  int          spotY [16];
  logic [15:0] spotV [16];

  logic [511:0] layoutA, layoutB;
  int           accepts, dones;

  chess_board_renderer dut (
    .clock        (clock),
    .resetApp     (resetApp),
    .Layout       (Layout),
    .frameRequest (frameRequest),
    .pixelReady   (pixelReady),
    .pixelWrite   (pixelWrite),
    .pixelData    (pixelData),
    .frameBusy    (frameBusy),
    .frameDone    (frameDone)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic addSpot(input int x, input int y, input logic [15:0] v);
    spotX[spotN] = x;
    spotY[spotN] = y;
    spotV[spotN] = v;
    spotN++;
  endtask

  // Runs one frame. abortAt >= 0 pulls reset after that many accepts;
  // stallAt holds pixelReady low 5 cycles on that pixel; changeAt rewrites
  // Layout to newLayout after that many accepts.
  task automatic runFrame(input int abortAt, input int stallAt, input int changeAt,
                          input logic [511:0] newLayout, output int nAcc, output int nDone);
    int   stall;
    bit   finished;
    bit   ready;
    logic [15:0] held;
    nAcc = 0; nDone = 0; stall = 0; finished = 0; held = '0;
    @(negedge clock);
    frameRequest = 1'b1;
    pixelReady   = 1'b1;
    @(posedge clock); #1;
    checkValue("busyAfterRequest", frameBusy, 1);
    checkValue("writeLowInLoad", pixelWrite, 0);
    @(posedge clock); #1;
    checkValue("writeHighAfterLoad", pixelWrite, 1);
    for (int cyc = 0; cyc < 80000 && !finished; cyc++) begin
      @(negedge clock);
      if (frameDone) begin
        nDone++;
        frameRequest = 1'b0;
        @(negedge clock);
        checkValue("donePulseWidth", frameDone, 0);
        checkValue("busyAfterDone", frameBusy, 0);
        finished = 1;
      end else if (abortAt >= 0 && nAcc == abortAt) begin
        resetApp = 1'b0;
        #1;
        checkValue("abortWrite", pixelWrite, 0);
        checkValue("abortData", pixelData, 0);
        checkValue("abortBusy", frameBusy, 0);
        checkValue("abortDone", frameDone, 0);
        @(negedge clock);
        resetApp     = 1'b1;
        frameRequest = 1'b0;
        pixelReady   = 1'b0;
        finished = 1;
      end else begin
        if (nAcc == changeAt) Layout = newLayout;
        ready = 1'b1;
        if (nAcc == stallAt && stall < 5) begin
          ready = 1'b0;
          if (stall == 0) held = pixelData;
          else begin
            checkValue("stallData", pixelData, held);
            checkValue("stallWrite", pixelWrite, 1);
          end
          stall++;
        end
        pixelReady = ready;
        if (pixelWrite && ready) begin
          for (int i = 0; i < spotN; i++)
            if (spotX[i] == nAcc % 240 && spotY[i] == nAcc / 240)
              checkValue($sformatf("pix(%0d,%0d)", spotX[i], spotY[i]), pixelData, spotV[i]);
          nAcc++;
        end
      end
    end
    if (!finished) checkValue("frameTimeout", 0, 1);
  endtask

  initial begin
    resetApp     = 1'b0;
    frameRequest = 1'b0;
    pixelReady   = 1'b0;
    Layout       = '0;
    repeat (3) @(posedge clock);
    #1;
    checkValue("resetWrite", pixelWrite, 0);
    checkValue("resetData", pixelData, 0);
    checkValue("resetBusy", frameBusy, 0);
    checkValue("resetDone", frameDone, 0);
    @(negedge clock);
    resetApp = 1'b1;

    // Frame 1: aborted by reset at pixel 500
    spotN = 0;
    runFrame(500, -1, -1, '0, accepts, dones);
    checkValue("abortAccepts", accepts, 500);

    // Frame 2: full frame from a fresh (0,0), stall on pixel 100,
    // Layout rewritten after 1000 pixels (old snapshot must persist)
    layoutA = '0;
    layoutA[0*8 +: 8]  = 8'h09;
    layoutA[2*8 +: 8]  = 8'h21;
    layoutA[19*8 +: 8] = 8'h10;
    layoutB = '0;
    layoutB[0*8 +: 8]  = 8'h50;
    Layout = layoutA;
    spotN = 0;
    addSpot(0,   0,   16'h0000);
    addSpot(0,   40,  16'hEF7D);
    addSpot(29,  40,  16'hEF7D);
    addSpot(30,  40,  16'h8A22);
    addSpot(239, 40,  16'h8A22);
    addSpot(15,  55,  16'hFFFF);
    addSpot(75,  55,  16'h2104);
    addSpot(64,  44,  16'h07E0);
    addSpot(90,  100, 16'hFFE0);
    addSpot(105, 115, 16'h8A22);
    addSpot(0,   279, 16'h8A22);
    addSpot(0,   280, 16'h0000);
    addSpot(239, 319, 16'h0000);
    runFrame(-1, 100, 1000, layoutB, accepts, dones);
    checkValue("frameAccepts", accepts, 76800);
    checkValue("framePulses", dones, 1);

    // Frame 3: the rewritten layout now shows (square 0 = lock cursor)
    spotN = 0;
    addSpot(0,  40, 16'hF800);
    addSpot(30, 40, 16'h8A22);
    addSpot(5,  45, 16'hEF7D);
    runFrame(10806, -1, -1, '0, accepts, dones);
    checkValue("frame3Accepts", accepts, 10806);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
`default_nettype wire
